id_exe_pipe: RTL and testbench

- Parametrised ID/EXE pipeline register with an elastic valid/ready handshake and a 2-entry skid buffer (output register plus one skid entry).
- Adds synchronous flush, load-use hazard detection with automatic bubble insertion, and a saturating stall counter.
- Sits between the decode stage and the ALU/EXE stage. It lets EXE back-pressure decode without losing an instruction, and replaces the single-entry flush/reset register.

---
 rtl/id_exe_pipe.sv | 126 ++++++++++++
 tb/tb_id_exe_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_pipe.sv
// ID/EXE pipeline register with an elastic valid/ready handshake and a
// two-entry skid buffer: the EXE-facing register plus one overflow entry.
// It also detects load-use hazards, inserting a bubble after the load, and
// counts the stalled cycles in a saturating counter.
// A flush kills everything held but keeps the stall count.
module id_exe_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_pc4,
    input  logic [DATA_W-1:0]  in_data1,
    input  logic [DATA_W-1:0]  in_data2,
    input  logic [DATA_W-1:0]  in_ext_imm,
    input  logic [REG_W-1:0]   in_rw,
    input  logic [REG_W-1:0]   in_rs,
    input  logic [REG_W-1:0]   in_rt,
    input  logic               in_uses_rt,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic               in_s_b,
    input  logic               in_reg_write,
    input  logic               in_mem_write,
    input  logic               in_memtoreg,
    input  logic [1:0]         in_s_data_write,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_pc4,
    output logic [DATA_W-1:0]  out_data1,
    output logic [DATA_W-1:0]  out_data2,
    output logic [DATA_W-1:0]  out_ext_imm,
    output logic [REG_W-1:0]   out_rw,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_s_b,
    output logic               out_reg_write,
    output logic               out_mem_write,
    output logic               out_memtoreg,
    output logic [1:0]         out_s_data_write,
    output logic               load_use_stall,
    output logic [CNT_W-1:0]   stall_cnt
);

    // The whole payload travels as one flat vector so the EXE register and
    // the skid entry can be copied and cleared in a single assignment.
    localparam int PAY_W = 4*DATA_W + 3*REG_W + ALUOP_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAY_W-1:0] r_mainPayload;
    logic             r_mainValid;
    logic [PAY_W-1:0] r_skidPayload;
    logic             r_skidValid;
    logic [CNT_W-1:0] r_stallCnt;

    logic [PAY_W-1:0] w_inPayload;
    logic             w_loadUseStall;
    logic             w_accept;
    logic             w_mainAdvance;

    assign w_inPayload = {in_pc4, in_data1, in_data2, in_ext_imm,
                          in_rw, in_rs, in_rt, in_aluop,
                          in_s_b, in_reg_write, in_mem_write, in_memtoreg,
                          in_s_data_write};

    assign {out_pc4, out_data1, out_data2, out_ext_imm,
            out_rw, out_rs, out_rt, out_aluop,
            out_s_b, out_reg_write, out_mem_write, out_memtoreg,
            out_s_data_write} = r_mainPayload;

    assign out_valid = r_mainValid;
    assign stall_cnt = r_stallCnt;

    // A load in EXE whose destination feeds a source of the decode
    // instruction must hold that instruction; register 0 is never a hazard.
    assign w_loadUseStall = in_valid & r_mainValid & out_memtoreg &
                            (out_rw != '0) &
                            ((out_rw == in_rs) | (in_uses_rt & (out_rw == in_rt)));

    assign load_use_stall = w_loadUseStall;
    assign in_ready       = !r_skidValid & !w_loadUseStall;
    assign w_accept       = in_valid & in_ready;
    assign w_mainAdvance  = !r_mainValid | out_ready;

    // Pipeline storage: the skid entry drains ahead of new input so ordering
    // is kept; with nothing to load, the EXE register becomes a zeroed bubble.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_mainPayload <= '0;
            r_mainValid   <= 1'b0;
            r_skidPayload <= '0;
            r_skidValid   <= 1'b0;
        end else if (w_mainAdvance) begin
            if (r_skidValid) begin
                r_mainPayload <= r_skidPayload;
                r_mainValid   <= 1'b1;
                r_skidPayload <= '0;
                r_skidValid   <= 1'b0;
            end else if (w_accept) begin
                r_mainPayload <= w_inPayload;
                r_mainValid   <= 1'b1;
            end else begin
                r_mainPayload <= '0;
                r_mainValid   <= 1'b0;
            end
        end else if (w_accept) begin
            r_skidPayload <= w_inPayload;
            r_skidValid   <= 1'b1;
        end
    end

    // Count every stalled cycle, sticking at all-ones; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stallCnt <= '0;
        end else if (w_loadUseStall && (r_stallCnt != CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_pipe.sv
// Directed bench for id_exe_pipe: streaming, back-pressure through the skid
// entry, load-use bubbles on rs and rt, flush, and counter saturation.
// The DUT uses a 2-bit stall counter so saturation is reachable quickly.
module tb_id_exe_pipe;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 5;
    localparam int CNT_W   = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_pc4, in_data1, in_data2, in_ext_imm;
    logic [REG_W-1:0]   in_rw, in_rs, in_rt;
    logic               in_uses_rt;
    logic [ALUOP_W-1:0] in_aluop;
    logic               in_s_b, in_reg_write, in_mem_write, in_memtoreg;
    logic [1:0]         in_s_data_write;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_pc4, out_data1, out_data2, out_ext_imm;
    logic [REG_W-1:0]   out_rw, out_rs, out_rt;
    logic [ALUOP_W-1:0] out_aluop;
    logic               out_s_b, out_reg_write, out_mem_write, out_memtoreg;
    logic [1:0]         out_s_data_write;
    logic               load_use_stall;
    logic [CNT_W-1:0]   stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    id_exe_pipe #(
        .DATA_W(DATA_W), .REG_W(REG_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc4(in_pc4), .in_data1(in_data1), .in_data2(in_data2),
        .in_ext_imm(in_ext_imm), .in_rw(in_rw), .in_rs(in_rs), .in_rt(in_rt),
        .in_uses_rt(in_uses_rt), .in_aluop(in_aluop), .in_s_b(in_s_b),
        .in_reg_write(in_reg_write), .in_mem_write(in_mem_write),
        .in_memtoreg(in_memtoreg), .in_s_data_write(in_s_data_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc4(out_pc4), .out_data1(out_data1), .out_data2(out_data2),
        .out_ext_imm(out_ext_imm), .out_rw(out_rw), .out_rs(out_rs),
        .out_rt(out_rt), .out_aluop(out_aluop), .out_s_b(out_s_b),
        .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
        .out_memtoreg(out_memtoreg), .out_s_data_write(out_s_data_write),
        .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // One comparison: count it, and on a miss count and report it.
    task automatic chk(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one decode instruction; every payload field is derived from pc4
    // so the output side can tell which instruction it sees.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [4:0] rw, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic usesRt,
                                 input logic memtoreg);
        in_valid        = v;
        in_pc4          = pc;
        in_data1        = pc + 32'h1000;
        in_data2        = pc + 32'h2000;
        in_ext_imm      = pc + 32'h3000;
        in_rw           = rw;
        in_rs           = rs;
        in_rt           = rt;
        in_uses_rt      = usesRt;
        in_aluop        = pc[6:2];
        in_s_b          = 1'b1;
        in_reg_write    = 1'b1;
        in_mem_write    = 1'b0;
        in_memtoreg     = memtoreg;
        in_s_data_write = 2'b01;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Compare the EXE register against the instruction with the given pc4,
    // or against an all-zero bubble when no valid entry is expected.
    task automatic checkOutput(input string tag, input logic expValid,
                               input logic [31:0] pc, input logic [4:0] rw,
                               input logic memtoreg);
        chk({tag, ".valid"}, 64'(out_valid), 64'(expValid));
        if (expValid) begin
            chk({tag, ".pc4"},   64'(out_pc4),   64'(pc));
            chk({tag, ".data1"}, 64'(out_data1), 64'(pc + 32'h1000));
            chk({tag, ".data2"}, 64'(out_data2), 64'(pc + 32'h2000));
            chk({tag, ".imm"},   64'(out_ext_imm), 64'(pc + 32'h3000));
            chk({tag, ".rw"},    64'(out_rw),    64'(rw));
            chk({tag, ".aluop"}, 64'(out_aluop), 64'(pc[6:2]));
            chk({tag, ".mtr"},   64'(out_memtoreg), 64'(memtoreg));
            chk({tag, ".ctl"},   64'({out_s_b, out_reg_write, out_mem_write, out_s_data_write}),
                64'(5'b11001));
        end else begin
            chk({tag, ".zero"},
                64'(|{out_pc4, out_data1, out_data2, out_ext_imm, out_rw, out_rs,
                      out_rt, out_aluop, out_s_b, out_reg_write, out_mem_write,
                      out_memtoreg, out_s_data_write}),
                64'(0));
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();

        // Reset held for two cycles.
        tick();
        tick();
        checkOutput("reset", 1'b0, 32'h0, 5'd0, 1'b0);
        chk("reset.cnt", 64'(stall_cnt), 64'(0));
        reset = 1'b0;

        // Back-to-back stream with EXE always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'(4*i), 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
            chk("stream.in_ready", 64'(in_ready), 64'(1));
            tick();
            checkOutput("stream", 1'b1, 32'(4*i), 5'd1, 1'b0);
        end
        idle();
        tick();
        checkOutput("stream.drain", 1'b0, 32'h0, 5'd0, 1'b0);

        // Back-pressure: 0x20 held in EXE, 0x24 parked in skid.
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h20, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checkOutput("bp.first", 1'b1, 32'h20, 5'd2, 1'b0);
        applyStimulus(1'b1, 32'h24, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("bp.ready_before", 64'(in_ready), 64'(1));
        tick();
        idle();
        checkOutput("bp.hold", 1'b1, 32'h20, 5'd2, 1'b0);
        chk("bp.skid_full", 64'(in_ready), 64'(0));
        tick();
        checkOutput("bp.hold2", 1'b1, 32'h20, 5'd2, 1'b0);
        chk("bp.skid_full2", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        tick();
        checkOutput("bp.skid_out", 1'b1, 32'h24, 5'd3, 1'b0);
        chk("bp.ready_after", 64'(in_ready), 64'(1));
        tick();
        checkOutput("bp.no_dup", 1'b0, 32'h0, 5'd0, 1'b0);

        // Load-use on rs: one bubble, then the dependent instruction.
        applyStimulus(1'b1, 32'h40, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        checkOutput("lu.load", 1'b1, 32'h40, 5'd5, 1'b1);
        applyStimulus(1'b1, 32'h44, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0);
        chk("lu.stall", 64'(load_use_stall), 64'(1));
        chk("lu.in_ready", 64'(in_ready), 64'(0));
        tick();
        checkOutput("lu.bubble", 1'b0, 32'h0, 5'd0, 1'b0);
        chk("lu.cnt", 64'(stall_cnt), 64'(1));
        chk("lu.stall_gone", 64'(load_use_stall), 64'(0));
        tick();
        checkOutput("lu.dep", 1'b1, 32'h44, 5'd6, 1'b0);
        idle();
        tick();

        // A load to register 0 never stalls.
        applyStimulus(1'b1, 32'h50, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h54, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("r0.stall", 64'(load_use_stall), 64'(0));
        chk("r0.in_ready", 64'(in_ready), 64'(1));
        tick();
        checkOutput("r0.dep", 1'b1, 32'h54, 5'd6, 1'b0);
        chk("r0.cnt", 64'(stall_cnt), 64'(1));
        idle();
        tick();

        // rt match only stalls when the instruction really reads rt.
        applyStimulus(1'b1, 32'h60, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h64, 5'd8, 5'd3, 5'd7, 1'b0, 1'b0);
        chk("rt.no_use", 64'(load_use_stall), 64'(0));
        tick();
        checkOutput("rt.no_use_out", 1'b1, 32'h64, 5'd8, 1'b0);
        applyStimulus(1'b1, 32'h68, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h6C, 5'd8, 5'd3, 5'd7, 1'b1, 1'b0);
        chk("rt.use", 64'(load_use_stall), 64'(1));
        tick();
        checkOutput("rt.bubble", 1'b0, 32'h0, 5'd0, 1'b0);
        chk("rt.cnt", 64'(stall_cnt), 64'(2));
        tick();
        checkOutput("rt.dep", 1'b1, 32'h6C, 5'd8, 1'b0);
        idle();
        tick();

        // Flush with both entries full.
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h80, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h84, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h88, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("fl.full", 64'(in_ready), 64'(0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checkOutput("fl.cleared", 1'b0, 32'h0, 5'd0, 1'b0);
        chk("fl.in_ready", 64'(in_ready), 64'(1));
        chk("fl.cnt", 64'(stall_cnt), 64'(2));
        out_ready = 1'b1;
        tick();
        checkOutput("fl.skid_gone", 1'b0, 32'h0, 5'd0, 1'b0);

        // Input presented during a flush is dropped even when accepted.
        applyStimulus(1'b1, 32'h90, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checkOutput("fl.drop", 1'b0, 32'h0, 5'd0, 1'b0);

        // Hold a hazard five cycles: the 2-bit counter sticks at 3.
        applyStimulus(1'b1, 32'hA0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'hA4, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat.cnt", 64'(stall_cnt), 64'(3));
        end
        checkOutput("sat.load_held", 1'b1, 32'hA0, 5'd9, 1'b1);

        // Reset wins over a simultaneous flush and clears the counter.
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        idle();
        checkOutput("rstfl", 1'b0, 32'h0, 5'd0, 1'b0);
        chk("rstfl.cnt", 64'(stall_cnt), 64'(0));
        chk("rstfl.in_ready", 64'(in_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
